// File: rtl/kbd_pkg.sv
// Shared constants and types for the keyboard scan controller: scancode values,
// parser states and the FIFO entry / STATUS word layouts.
package kbd_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ECHO   = 8'hEE;

    localparam int unsigned BUS_W = 16;

    typedef enum logic [1:0] {
        PS_IDLE      = 2'd0,
        PS_EXT       = 2'd1,
        PS_BREAK     = 2'd2,
        PS_EXT_BREAK = 2'd3
    } parse_state_t;

    // FIFO entry: [15]=ext, [14]=shift at push time, [13:8]=0, [7:0]=scancode
    typedef struct packed {
        logic       ext;
        logic       shift;
        logic [5:0] rsvd;
        logic [7:0] code;
    } kbd_entry_t;

    typedef struct packed {
        logic       overflow;
        logic       shift;
        logic [5:0] rsvd;
        logic [7:0] count;
    } kbd_status_t;

    // Keyboard housekeeping replies that never represent a key
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == SC_ACK) || (b == SC_BAT_OK) || (b == SC_RESEND) || (b == SC_ECHO);
    endfunction

endpackage

// File: rtl/keyboard_scan_controller_if.sv
// Byte stream from the PS/2 receiver into the scan controller.
interface keyboard_scan_controller_if;
    logic [7:0] scan_byte;
    logic       scan_valid;

    modport master (output scan_byte, output scan_valid);
    modport slave  (input  scan_byte, input  scan_valid);
endinterface

// File: rtl/kbd_fifo.sv
// Synchronous FIFO of keyboard entries; flush overrides push and pop in the same cycle.
module kbd_fifo
    import kbd_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  kbd_entry_t             i_data,
    output kbd_entry_t             o_head_c,
    output logic                   o_full_c,
    output logic                   o_empty_c,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    kbd_entry_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full_c  = (r_count == CW'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_head_c  = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // A pop frees the slot a same-cycle push needs when full
    assign w_do_pop  = i_pop & ~o_empty_c & ~i_flush;
    assign w_do_push = i_push & (~o_full_c | w_do_pop) & ~i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/triState.sv
// Tri-state pad driver shared by the bus peripherals.
module triState #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output wire  [WIDTH-1:0] o_pad
);
    assign o_pad = i_en ? i_data : {WIDTH{1'bz}};
endmodule

// File: rtl/keyboard_scan_controller.sv
// PS/2 scancode parser with shift tracking, make-code FIFO and a two-word
// memory-mapped CPU interface (STATUS at BASE, DATA at BASE+1).
module keyboard_scan_controller
    import kbd_pkg::*;
#(
    parameter int unsigned BASE  = 0,
    parameter int unsigned DEPTH = 8
) (
    input  logic                        CLOCK_50,
    input  logic                        reset_n,
    keyboard_scan_controller_if.slave   scan,
    inout  wire  [BUS_W-1:0]            BUS,
    input  logic [31:0]                 address,
    input  logic                        writeEn,
    input  logic                        outputEn,
    output wire                         readDone,
    output logic                        irq
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    parse_state_t     r_pstate;
    logic             r_shift_l;
    logic             r_shift_r;
    logic             r_ovf;
    logic             r_active;
    logic [BUS_W-1:0] r_hold;
    logic             r_rd_done;
    logic             r_irq;

    logic             w_cs_status, w_cs_data, w_cs;
    logic             w_push, w_pop, w_flush, w_clr_ovf, w_first;
    logic             w_full, w_empty;
    logic [CW-1:0]    w_count;
    kbd_entry_t       w_entry, w_head;
    kbd_status_t      w_status;
    logic [BUS_W-1:0] w_head_word, w_bus_out;
    logic             w_shift;

    assign w_shift     = r_shift_l | r_shift_r;
    assign w_cs_status = (address == 32'(BASE));
    assign w_cs_data   = (address == 32'(BASE) + 32'd1);
    assign w_cs        = w_cs_status | w_cs_data;

    // Make-code decode: which incoming byte becomes a FIFO entry
    always_comb begin
        w_push        = 1'b0;
        w_entry       = '0;
        w_entry.shift = w_shift;
        w_entry.code  = scan.scan_byte;
        if (scan.scan_valid) begin
            case (r_pstate)
                PS_IDLE: w_push = (scan.scan_byte != SC_EXT) && (scan.scan_byte != SC_BREAK) &&
                                  (scan.scan_byte != SC_LSHIFT) && (scan.scan_byte != SC_RSHIFT) &&
                                  !is_ignored(scan.scan_byte);
                PS_EXT: begin
                    w_push      = (scan.scan_byte != SC_BREAK);
                    w_entry.ext = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Prefix tracking and shift state
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_pstate  <= PS_IDLE;
            r_shift_l <= 1'b0;
            r_shift_r <= 1'b0;
        end else if (scan.scan_valid) begin
            case (r_pstate)
                PS_IDLE: begin
                    if (scan.scan_byte == SC_EXT)         r_pstate  <= PS_EXT;
                    else if (scan.scan_byte == SC_BREAK)  r_pstate  <= PS_BREAK;
                    else if (scan.scan_byte == SC_LSHIFT) r_shift_l <= 1'b1;
                    else if (scan.scan_byte == SC_RSHIFT) r_shift_r <= 1'b1;
                end
                PS_EXT:   r_pstate <= (scan.scan_byte == SC_BREAK) ? PS_EXT_BREAK : PS_IDLE;
                PS_BREAK: begin
                    if (scan.scan_byte == SC_LSHIFT) r_shift_l <= 1'b0;
                    if (scan.scan_byte == SC_RSHIFT) r_shift_r <= 1'b0;
                    r_pstate <= PS_IDLE;
                end
                default:  r_pstate <= PS_IDLE;
            endcase
        end
    end

    assign w_first   = w_cs_data & outputEn & ~writeEn & ~r_active;
    assign w_pop     = w_first & ~w_empty;
    assign w_flush   = w_cs_status & writeEn & BUS[0];
    assign w_clr_ovf = w_cs_status & writeEn & (BUS[0] | BUS[1]);

    kbd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (CLOCK_50),
        .rst_n    (reset_n),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_flush  (w_flush),
        .i_data   (w_entry),
        .o_head_c (w_head),
        .o_full_c (w_full),
        .o_empty_c(w_empty),
        .o_count  (w_count)
    );

    // CPU side: sticky overflow, one-pop-per-access hold register, readDone, irq
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf     <= 1'b0;
            r_active  <= 1'b0;
            r_hold    <= '0;
            r_rd_done <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_clr_ovf)                          r_ovf <= 1'b0;
            else if (w_push && w_full && !w_pop)    r_ovf <= 1'b1;
            if (w_first)                            r_active <= 1'b1;
            else if (!(w_cs_data && outputEn))      r_active <= 1'b0;
            if (w_first)                            r_hold <= w_head_word;
            r_rd_done <= w_cs & ~writeEn;
            r_irq     <= (w_count != '0);
        end
    end

    assign w_head_word     = w_empty ? '0 : w_head;
    assign w_status.overflow = r_ovf;
    assign w_status.shift    = w_shift;
    assign w_status.rsvd     = '0;
    assign w_status.count    = 8'(w_count);
    assign w_bus_out       = w_cs_data ? (r_active ? r_hold : w_head_word) : w_status;
    assign irq             = r_irq;

    // Reset releases the bus at once, even mid-access
    triState #(.WIDTH(BUS_W)) u_bus_drv (
        .i_en  (outputEn & w_cs & reset_n),
        .i_data(w_bus_out),
        .o_pad (BUS)
    );

    triState #(.WIDTH(1)) u_done_drv (
        .i_en  (w_cs & reset_n),
        .i_data(r_rd_done),
        .o_pad (readDone)
    );

endmodule

// File: tb/tb_keyboard_scan_controller.sv
// Self-checking bench for keyboard_scan_controller: directed table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_keyboard_scan_controller;

    localparam int unsigned BASE  = 16;
    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] ADDR_NONE = 32'h100;

    logic        clk;
    logic        reset_n;
    logic [31:0] address;
    logic        writeEn;
    logic        outputEn;
    wire  [15:0] BUS;
    wire         readDone;
    logic        irq;
    logic        tb_drv;
    logic [15:0] tb_wdata;

    keyboard_scan_controller_if scan_if ();

    assign BUS = tb_drv ? tb_wdata : 16'hzzzz;

    // Pull-ups make an undriven bus read as all ones
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (BUS[g]);
    end
    pullup (readDone);

    keyboard_scan_controller #(.BASE(BASE), .DEPTH(DEPTH)) dut (
        .CLOCK_50(clk),
        .reset_n (reset_n),
        .scan    (scan_if),
        .BUS     (BUS),
        .address (address),
        .writeEn (writeEn),
        .outputEn(outputEn),
        .readDone(readDone),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: prefix flags, shift keys, overflow and an entry queue
    logic [15:0] mq[$];
    logic        m_l, m_r, m_ext, m_brk, m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_l = 0; m_r = 0; m_ext = 0; m_brk = 0; m_ovf = 0;
    endtask

    task automatic m_push(input logic [15:0] e);
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1'b1;
    endtask

    task automatic m_byte(input logic [7:0] b);
        logic sh;
        sh = m_l | m_r;
        if (m_brk) begin
            if (!m_ext) begin
                if (b == 8'h12) m_l = 1'b0;
                if (b == 8'h59) m_r = 1'b0;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1'b1;
            else begin
                m_push({1'b1, sh, 6'b0, b});
                m_ext = 1'b0;
            end
        end else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'h12) m_l = 1'b1;
        else if (b == 8'h59) m_r = 1'b1;
        else if (!(b inside {8'hFA, 8'hAA, 8'hFE, 8'hEE})) m_push({1'b0, sh, 6'b0, b});
    endtask

    function automatic logic [15:0] m_status();
        return {m_ovf, m_l | m_r, 6'b0, 8'(mq.size())};
    endfunction

    task automatic send(input logic [7:0] b);
        scan_if.scan_valid = 1'b1;
        scan_if.scan_byte  = b;
        m_byte(b);
        @(negedge clk);
        scan_if.scan_valid = 1'b0;
    endtask

    task automatic rd_status(output logic [15:0] v);
        address  = 32'(BASE);
        outputEn = 1'b1;
        #1 v = BUS;
        check("rd_status_done_early", readDone, 1'b0);
        @(negedge clk);
        check("rd_status_done", readDone, 1'b1);
        check("irq", irq, mq.size() != 0);
        outputEn = 1'b0;
        address  = ADDR_NONE;
        @(negedge clk);
    endtask

    task automatic rd_data(output logic [15:0] v);
        address  = 32'(BASE) + 32'd1;
        outputEn = 1'b1;
        #1 v = BUS;
        check("rd_data_done_early", readDone, 1'b0);
        @(negedge clk);
        check("rd_data_done", readDone, 1'b1);
        check("rd_data_stable", BUS, v);
        outputEn = 1'b0;
        address  = ADDR_NONE;
        @(negedge clk);
    endtask

    task automatic rd_data_model(input string name);
        logic [15:0] v, e;
        e = (mq.size() != 0) ? mq.pop_front() : 16'h0000;
        rd_data(v);
        check(name, v, e);
    endtask

    task automatic wr_status(input logic [15:0] d);
        address  = 32'(BASE);
        writeEn  = 1'b1;
        tb_drv   = 1'b1;
        tb_wdata = d;
        if (d[0]) begin mq.delete(); m_ovf = 1'b0; end
        else if (d[1]) m_ovf = 1'b0;
        @(negedge clk);
        writeEn = 1'b0;
        tb_drv  = 1'b0;
        address = ADDR_NONE;
        @(negedge clk);
    endtask

    typedef struct packed {
        logic [55:0] seq;
        int          n;
        logic [31:0] exp;
        int          n_exp;
        logic        shift;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [15:0] v;
        logic [7:0]  b;

        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        logic [7:0]  b;
        int          k;

        vt[0] = '{seq: 56'h1C_00_00_00_00_00_00, n: 1, exp: 32'h001C_0000, n_exp: 1, shift: 1'b0};
        vt[1] = '{seq: 56'h12_1C_F0_12_1C_00_00, n: 5, exp: 32'h401C_001C, n_exp: 2, shift: 1'b0};
        vt[2] = '{seq: 56'hE0_75_E0_F0_75_F0_1C, n: 7, exp: 32'h8075_0000, n_exp: 1, shift: 1'b0};
        vt[3] = '{seq: 56'h59_E0_12_00_00_00_00, n: 3, exp: 32'hC012_0000, n_exp: 1, shift: 1'b1};
        vt[4] = '{seq: 56'hF0_59_FA_AA_FE_EE_1C, n: 7, exp: 32'h001C_0000, n_exp: 1, shift: 1'b0};
        vt[5] = '{seq: 56'hE0_F0_12_12_00_00_00, n: 4, exp: 32'h0000_0000, n_exp: 0, shift: 1'b1};
        vt[6] = '{seq: 56'hF0_12_1C_00_00_00_00, n: 3, exp: 32'h001C_0000, n_exp: 1, shift: 1'b0};

        m_reset();
        reset_n = 1'b0;
        address = ADDR_NONE;
        writeEn = 1'b0;
        outputEn = 1'b1;
        tb_drv = 1'b0;
        tb_wdata = '0;
        scan_if.scan_valid = 1'b0;
        scan_if.scan_byte  = '0;

        // Reset state
        #1;
        check("reset_bus_z", BUS, 16'hFFFF);
        check("reset_irq", irq, 1'b0);
        outputEn = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd_status(v);
        check("reset_status", v, 16'h0000);

        // Directed table: bytes streamed back-to-back, then drained
        foreach (vt[i]) begin
            wr_status(16'h0001);
            for (int j = 0; j < vt[i].n; j++) send(vt[i].seq[55-8*j -: 8]);
            @(negedge clk);
            rd_status(v);
            check($sformatf("vec%0d_status", i), v, {1'b0, vt[i].shift, 6'b0, 8'(vt[i].n_exp)});
            for (int j = 0; j < vt[i].n_exp; j++) begin
                rd_data(v);
                check($sformatf("vec%0d_entry%0d", i, j), v, vt[i].exp[31-16*j -: 16]);
                if (mq.size() != 0) void'(mq.pop_front());
            end
            rd_status(v);
            check($sformatf("vec%0d_drained", i), v, {1'b0, vt[i].shift, 14'b0});
        end

        // Overflow and the two STATUS clear bits
        wr_status(16'h0001);
        for (int i = 0; i <= DEPTH; i++) send(8'h20 + 8'(i));
        rd_status(v);
        check("ovf_status", v, 16'h8008);
        wr_status(16'h0001);
        rd_status(v);
        check("flush_status", v, 16'h0000);
        for (int i = 0; i <= DEPTH; i++) send(8'h20 + 8'(i));
        wr_status(16'h0002);
        rd_status(v);
        check("clr_ovf_status", v, 16'h0008);

        // Push and pop in the same cycle while full
        scan_if.scan_valid = 1'b1;
        scan_if.scan_byte  = 8'h30;
        address  = 32'(BASE) + 32'd1;
        outputEn = 1'b1;
        void'(mq.pop_front());
        m_byte(8'h30);
        #1 v = BUS;
        check("full_pushpop_data", v, 16'h0020);
        @(negedge clk);
        scan_if.scan_valid = 1'b0;
        outputEn = 1'b0;
        address  = ADDR_NONE;
        @(negedge clk);
        rd_status(v);
        check("full_pushpop_status", v, 16'h0008);

        // Flush and push in the same cycle
        send(8'h31);
        address  = 32'(BASE);
        writeEn  = 1'b1;
        tb_drv   = 1'b1;
        tb_wdata = 16'h0001;
        scan_if.scan_valid = 1'b1;
        scan_if.scan_byte  = 8'h1C;
        mq.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        scan_if.scan_valid = 1'b0;
        writeEn = 1'b0;
        tb_drv  = 1'b0;
        address = ADDR_NONE;
        @(negedge clk);
        rd_status(v);
        check("flush_push_status", v, 16'h0000);

        // Read of an empty FIFO returns zero without underflow
        rd_data(v);
        check("empty_read", v, 16'h0000);
        rd_status(v);
        check("empty_status", v, 16'h0000);

        // Held DATA read: one pop, value stable for the whole access
        send(8'h15);
        send(8'h16);
        address  = 32'(BASE) + 32'd1;
        outputEn = 1'b1;
        #1 check("hold_first", BUS, 16'h0015);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold_cycle%0d", i), BUS, 16'h0015);
        end
        outputEn = 1'b0;
        address  = ADDR_NONE;
        void'(mq.pop_front());
        @(negedge clk);
        rd_status(v);
        check("hold_status", v, 16'h0001);
        rd_data(v);
        check("hold_second", v, 16'h0016);
        void'(mq.pop_front());

        // Reset in the middle of a read
        send(8'h12);
        send(8'h1C);
        send(8'h2D);
        send(8'h3E);
        address  = 32'(BASE) + 32'd1;
        outputEn = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        m_reset();
        #1;
        check("midrd_reset_bus_z", BUS, 16'hFFFF);
        check("midrd_reset_done_z", readDone, 1'b1);
        check("midrd_reset_irq", irq, 1'b0);
        @(negedge clk);
        outputEn = 1'b0;
        address  = ADDR_NONE;
        reset_n  = 1'b1;
        @(negedge clk);
        rd_status(v);
        check("midrd_reset_status", v, 16'h0000);

        // Randomized traffic against the reference model
        for (int it = 0; it < 400; it++) begin
            k = int'($urandom_range(0, 9));
            if (k <= 5) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
                    case ($urandom_range(0, 8))
                        0: b = 8'h12;
                        1: b = 8'h59;
                        2: b = 8'hE0;
                        3: b = 8'hF0;
                        4: b = 8'hFA;
                        5: b = 8'hEE;
                        default: b = 8'($urandom_range(1, 8'h7F));
                    endcase
                    send(b);
                end
            end else if (k <= 7) begin
                rd_data_model("rand_data");
            end else if (k == 8) begin
                rd_status(v);
                check("rand_status", v, m_status());
            end else begin
                wr_status(16'($urandom_range(0, 3)));
            end
        end
        rd_status(v);
        check("rand_final_status", v, m_status());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
